mac_dot_sequencer: RTL and testbench

Operand-pair sequencer for the INT16 MAC datapath: buffers (A,B) pairs in a small FIFO and issues them to the MAC one at a time over a start/done handshake. Computes an N-term dot product without CPU intervention per element. Sits between the TinyQV register interface (push/run/status) and the MAC core's operand, start, clear and done signals. Raises a sticky completion flag usable as an interrupt source.

---
 rtl/mac_dot_sequencer.sv | 130 +++++++++++++
 tb/tb_mac_dot_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sequencer.sv
// Operand-pair FIFO and sequencer feeding an INT16 MAC over a start/done
// handshake; runs an N-term dot product and raises a sticky done flag.
module mac_dot_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_valid,
  input  logic [15:0]                push_a,
  input  logic [15:0]                push_b,
  output logic                       push_ready,
  input  logic                       run,
  input  logic [LEN_W-1:0]           run_len,
  input  logic                       run_clear,
  input  logic                       abort,
  input  logic                       done_clr,
  output logic [15:0]                mac_op_a,
  output logic [15:0]                mac_op_b,
  output logic                       mac_clear,
  output logic                       mac_start,
  input  logic                       mac_done,
  output logic                       busy,
  output logic                       done,
  output logic [LEN_W-1:0]           remaining,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_ISSUE, S_WAIT} state_t;

  state_t          state, state_nxt;
  logic [15:0]     mem_a [DEPTH];
  logic [15:0]     mem_b [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            fifo_empty, push_acc, pop, run_acc, wait_done, last_done;

  assign push_ready = (fifo_level != LW'(DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign push_acc   = push_valid && push_ready && !abort;
  assign pop        = (state == S_FETCH) && !fifo_empty && !abort;
  assign run_acc    = (state == S_IDLE) && run && !abort;
  assign wait_done  = (state == S_WAIT) && mac_done && !abort;
  assign last_done  = wait_done && (remaining == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_a[wr_ptr] <= push_a;
      mem_b[wr_ptr] <= push_b;
    end
  end

  // Abort flushes by resetting both pointers; any stored data becomes dead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      case ({push_acc, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (run && run_len != '0) state_nxt = run_clear ? S_CLEAR : S_FETCH;
        S_CLEAR: state_nxt = S_FETCH;
        S_FETCH: if (!fifo_empty) state_nxt = S_ISSUE;
        S_ISSUE: state_nxt = S_WAIT;
        S_WAIT:  if (mac_done) state_nxt = (remaining == LEN_W'(1)) ? S_IDLE : S_FETCH;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mac_clear = 1'b0;
    mac_start = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE:  busy      = 1'b0;
      S_CLEAR: mac_clear = 1'b1;
      S_ISSUE: mac_start = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_op_a  <= '0;
      mac_op_b  <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      if (pop) begin
        mac_op_a <= mem_a[rd_ptr];
        mac_op_b <= mem_b[rd_ptr];
      end
      if (abort)          remaining <= '0;
      else if (run_acc)   remaining <= run_len;
      else if (wait_done) remaining <= remaining - LEN_W'(1);
      // Accepted run and completion both take priority over done_clr.
      if (run_acc)        done <= (run_len == '0);
      else if (last_done) done <= 1'b1;
      else if (done_clr)  done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with a 1-cycle-latency MAC model.
module tb_mac_dot_sequencer;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LEN_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic push_valid = 1'b0, run = 1'b0, run_clear = 1'b0, abort = 1'b0, done_clr = 1'b0;
  logic [15:0] push_a = '0, push_b = '0;
  logic [LEN_W-1:0] run_len = '0;
  logic push_ready, mac_clear, mac_start, mac_done, busy, done;
  logic [15:0] mac_op_a, mac_op_b;
  logic [LEN_W-1:0] remaining;
  logic [$clog2(DEPTH):0] fifo_level;

  always #5 clk = ~clk;

  mac_dot_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_a(push_a), .push_b(push_b),
    .push_ready(push_ready), .run(run), .run_len(run_len), .run_clear(run_clear),
    .abort(abort), .done_clr(done_clr), .mac_op_a(mac_op_a), .mac_op_b(mac_op_b),
    .mac_clear(mac_clear), .mac_start(mac_start), .mac_done(mac_done), .busy(busy),
    .done(done), .remaining(remaining), .fifo_level(fifo_level)
  );

  // MAC model: done one cycle after start, accumulates products
  logic auto_mac = 1'b1, force_done = 1'b0, mac_done_q;
  logic [31:0] acc;
  int n_start = 0, n_clear = 0, n_mdone = 0;
  logic [15:0] iss_a[$], iss_b[$];
  assign mac_done = mac_done_q | force_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_done_q <= 1'b0;
      acc <= '0;
    end else begin
      mac_done_q <= mac_start && auto_mac;
      if (mac_clear) acc <= '0;
      else if (mac_start) acc <= acc + 32'(mac_op_a) * 32'(mac_op_b);
    end
  end

  always @(posedge clk) begin
    if (mac_start) begin
      n_start <= n_start + 1;
      iss_a.push_back(mac_op_a);
      iss_b.push_back(mac_op_b);
    end
    if (mac_clear) n_clear <= n_clear + 1;
    if (mac_done)  n_mdone <= n_mdone + 1;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int maxc);
    int k = 0;
    while (!done && k < maxc) begin
      tick();
      k++;
    end
    chk("done_within_bound", 32'(done), 1);
  endtask

  typedef struct {
    logic pv; logic [15:0] a, b; logic run; logic [7:0] len; logic rclr;
    logic busy, start, mclr, done; logic [3:0] lvl; logic [7:0] rem; logic [15:0] oa, ob;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(input logic pv, input logic [15:0] a, input logic [15:0] b,
                              input logic r, input logic [7:0] len, input logic rclr,
                              input logic bz, input logic st, input logic mc, input logic dn,
                              input logic [3:0] lvl, input logic [7:0] rem,
                              input logic [15:0] oa, input logic [15:0] ob);
    vec_t v;
    v.pv = pv; v.a = a; v.b = b; v.run = r; v.len = len; v.rclr = rclr;
    v.busy = bz; v.start = st; v.mclr = mc; v.done = dn; v.lvl = lvl; v.rem = rem;
    v.oa = oa; v.ob = ob;
    return v;
  endfunction

  initial begin
    int base, sbase, k;
    // Four pushes, run_len=4 with clear, then cycle-by-cycle sequence
    vt.push_back(mk(1, 1, 2, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0));
    vt.push_back(mk(1, 3, 4, 0, 0, 0,  0, 0, 0, 0, 2, 0, 0, 0));
    vt.push_back(mk(1, 5, 6, 0, 0, 0,  0, 0, 0, 0, 3, 0, 0, 0));
    vt.push_back(mk(1, 7, 8, 0, 0, 0,  0, 0, 0, 0, 4, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 4, 1,  1, 0, 1, 0, 4, 4, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4, 4, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 3, 4, 1, 2));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3, 4, 1, 2));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3, 3, 1, 2));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2, 3, 3, 4));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 2, 3, 3, 4));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 2, 2, 3, 4));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 2, 5, 6));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 2, 5, 6));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 1, 5, 6));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1, 7, 8));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 7, 8));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 7, 8));

    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_remaining", 32'(remaining), 0);
    chk("rst_start_clear", {30'd0, mac_start, mac_clear}, 0);
    chk("rst_ops", {mac_op_a, mac_op_b}, 0);
    chk("rst_push_ready", 32'(push_ready), 1);
    rst_n = 1'b1;
    tick();

    foreach (vt[i]) begin
      push_valid = vt[i].pv; push_a = vt[i].a; push_b = vt[i].b;
      run = vt[i].run; run_len = vt[i].len; run_clear = vt[i].rclr;
      tick();
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].busy));
      chk($sformatf("v%0d_start", i), 32'(mac_start), 32'(vt[i].start));
      chk($sformatf("v%0d_clear", i), 32'(mac_clear), 32'(vt[i].mclr));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vt[i].done));
      chk($sformatf("v%0d_level", i), 32'(fifo_level), 32'(vt[i].lvl));
      chk($sformatf("v%0d_remaining", i), 32'(remaining), 32'(vt[i].rem));
      chk($sformatf("v%0d_op_a", i), 32'(mac_op_a), 32'(vt[i].oa));
      chk($sformatf("v%0d_op_b", i), 32'(mac_op_b), 32'(vt[i].ob));
    end
    push_valid = 0; run = 0; run_len = 0; run_clear = 0;
    tick();
    chk("dot4_acc", acc, 100);
    chk("dot4_starts", 32'(n_start), 4);
    chk("dot4_clears", 32'(n_clear), 1);

    // run_len = 0: immediate done, never busy
    done_clr = 1; tick(); done_clr = 0;
    chk("done_clr", 32'(done), 0);
    sbase = n_start;
    run = 1; run_len = 0; run_clear = 1; tick(); run = 0; run_clear = 0;
    chk("len0_done", 32'(done), 1);
    chk("len0_busy", 32'(busy), 0);
    tick(); tick();
    chk("len0_busy_later", 32'(busy), 0);
    chk("len0_no_pulses", 32'(n_start - sbase) + 32'(n_clear), 1);

    // Stall on empty FIFO, pairs trickle in 10 cycles apart
    done_clr = 1; tick(); done_clr = 0;
    run = 1; run_len = 3; tick(); run = 0;
    chk("stall_busy", 32'(busy), 1);
    chk("stall_done_low", 32'(done), 0);
    sbase = n_start;
    for (int p = 0; p < 3; p++) begin
      repeat (8) tick();
      chk($sformatf("stall%0d_no_start", p), 32'(n_start - sbase), 32'(p));
      push_valid = 1; push_a = 16'(20 + p); push_b = 16'(30 + p);
      tick(); push_valid = 0;
      tick();
      chk($sformatf("stall%0d_start", p), 32'(mac_start), 1);
      chk($sformatf("stall%0d_op_a", p), 32'(mac_op_a), 32'(20 + p));
    end
    tick();
    chk("stall_not_done_in_wait", 32'(done), 0);
    tick();
    chk("stall_done", 32'(done), 1);
    chk("stall_idle", 32'(busy), 0);

    // Overfill then run DEPTH across the pointer wrap
    for (int i = 0; i <= DEPTH; i++) begin
      push_valid = 1; push_a = 16'(100 + i); push_b = 16'(200 + i);
      tick();
      if (i == DEPTH - 2) chk("fill_ready_before_full", 32'(push_ready), 1);
      if (i >= DEPTH - 1) begin
        chk($sformatf("fill%0d_ready", i), 32'(push_ready), 0);
        chk($sformatf("fill%0d_level", i), 32'(fifo_level), DEPTH);
      end
    end
    push_valid = 0;
    base = iss_a.size();
    run = 1; run_len = 8'(DEPTH); tick(); run = 0;
    wait_done(200);
    chk("wrap_count", 32'(iss_a.size() - base), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (base + i < iss_a.size()) begin
        chk($sformatf("wrap%0d_a", i), 32'(iss_a[base + i]), 32'(100 + i));
        chk($sformatf("wrap%0d_b", i), 32'(iss_b[base + i]), 32'(200 + i));
      end
    end
    chk("wrap_level", 32'(fifo_level), 0);

    // Abort after the 2nd mac_done, with a same-cycle push
    done_clr = 1; tick(); done_clr = 0;
    for (int i = 0; i < 5; i++) begin
      push_valid = 1; push_a = 16'(i); push_b = 16'(i); tick();
    end
    push_valid = 0;
    base = n_mdone; sbase = n_start;
    run = 1; run_len = 5; tick(); run = 0;
    k = 0;
    while (n_mdone < base + 2 && k < 50) begin tick(); k++; end
    chk("abort_reach_2nd_done", 32'(n_mdone - base), 2);
    abort = 1; push_valid = 1; tick(); abort = 0; push_valid = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_level", 32'(fifo_level), 0);
    chk("abort_remaining", 32'(remaining), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_start", 32'(mac_start), 0);
    auto_mac = 0; force_done = 1; tick(); force_done = 0; tick();
    chk("stray_done_remaining", 32'(remaining), 0);
    chk("stray_done_flag", 32'(done), 0);
    chk("stray_done_busy", 32'(busy), 0);
    chk("abort_starts", 32'(n_start - sbase), 2);
    auto_mac = 1;

    // Run while busy is ignored; done_clr loses to completion
    for (int i = 0; i < 2; i++) begin
      push_valid = 1; push_a = 16'(i + 1); push_b = 16'(3); tick();
    end
    push_valid = 0;
    run = 1; run_len = 2; tick();
    run_len = 7; tick(); run = 0;
    chk("rerun_remaining", 32'(remaining), 2);
    k = 0;
    while (!(mac_done && remaining == 1) && k < 50) begin tick(); k++; end
    done_clr = 1; tick(); done_clr = 0;
    chk("clr_vs_complete_done", 32'(done), 1);
    chk("clr_vs_complete_busy", 32'(busy), 0);
    chk("clr_vs_complete_rem", 32'(remaining), 0);
    run = 1; run_len = 3; done_clr = 1; tick(); run = 0; done_clr = 0;
    chk("run_vs_clr_done", 32'(done), 0);
    chk("run_vs_clr_busy", 32'(busy), 1);
    abort = 1; tick(); abort = 0;
    chk("final_abort_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end
endmodule
